// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants: M-extension funct3 codes, ALU control codes
// and the state encoding of the iterative multiply/divide unit.
package riscv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_MULDIV
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_DONE
  } md_state_e;

  localparam logic [5:0] MD_ITERS = 6'd32;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide sharing one 64-bit working register and one 33-bit adder.
module mul_div_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output md_state_e       state
);

  // Handshake: start is taken in IDLE or DONE when busy is low; done pulses
  // for one cycle with result valid; busy and done are never high together.
  md_state_e   state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [63:0] work_q, work_d;
  logic [31:0] opnd_q, opnd_d;
  logic [2:0]  op_q, op_d;
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;
  logic        fast_q, fast_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  // Operand conditioning for a new request
  logic        a_signed, b_signed, sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic        div_zero, div_ovf;
  logic [31:0] fast_res;

  always_comb begin
    a_signed = (op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM);
    b_signed = (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
    sign_a   = a_signed && src_a[31];
    sign_b   = b_signed && src_b[31];
    mag_a    = sign_a ? (32'd0 - src_a) : src_a;
    mag_b    = sign_b ? (32'd0 - src_b) : src_b;
    div_zero = op[2] && (src_b == 32'd0);
    div_ovf  = ((op == F3_DIV) || (op == F3_REM)) &&
               (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
    if (div_zero) fast_res = op[1] ? src_a : 32'hFFFF_FFFF;
    else          fast_res = op[1] ? 32'd0 : 32'h8000_0000;
  end

  // Shared adder: divide subtracts the divisor from the shifted partial
  // remainder, multiply adds the multiplicand into the high half.
  logic        is_div;
  logic [32:0] lhs, addend;
  logic [33:0] sum;
  logic        ge;
  logic [63:0] step;

  always_comb begin
    is_div = op_q[2];
    lhs    = is_div ? {work_q[63:32], work_q[31]} : {1'b0, work_q[63:32]};
    if (is_div)         addend = ~{1'b0, opnd_q};
    else if (work_q[0]) addend = {1'b0, opnd_q};
    else                addend = 33'd0;
    sum  = {1'b0, lhs} + {1'b0, addend} + {33'd0, is_div};
    ge   = sum[33];
    if (is_div) step = {(ge ? sum[31:0] : lhs[31:0]), work_q[30:0], ge};
    else        step = {sum[32:0], work_q[31:1]};
  end

  // Sign fix-up applied when the result is committed
  logic [63:0] prod;
  logic [31:0] quo, rem, final_res;

  always_comb begin
    prod = neg_q ? (64'd0 - work_q) : work_q;
    quo  = neg_q ? (32'd0 - work_q[31:0]) : work_q[31:0];
    rem  = neg_rem_q ? (32'd0 - work_q[63:32]) : work_q[63:32];
    if (fast_q)              final_res = work_q[31:0];
    else if (is_div)         final_res = op_q[1] ? rem : quo;
    else if (op_q == F3_MUL) final_res = prod[31:0];
    else                     final_res = prod[63:32];
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    work_d    = work_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    fast_d    = fast_q;
    result_d  = result_q;
    done_d    = 1'b0;
    if (flush) begin
      state_d = MD_IDLE;
      count_d = 6'd0;
    end else begin
      case (state_q)
        MD_IDLE, MD_DONE: begin
          state_d = MD_IDLE;
          if (start) begin
            state_d   = MD_RUN;
            count_d   = 6'd0;
            op_d      = op;
            fast_d    = div_zero || div_ovf;
            neg_d     = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            opnd_d    = op[2] ? mag_b : mag_a;
            if (div_zero || div_ovf) work_d = {32'd0, fast_res};
            else if (op[2])          work_d = {32'd0, mag_a};
            else                     work_d = {32'd0, mag_b};
          end
        end
        MD_RUN: begin
          if (fast_q || (count_q == MD_ITERS)) begin
            result_d = final_res;
            state_d  = MD_DONE;
            done_d   = 1'b1;
          end else begin
            work_d  = step;
            count_d = count_q + 6'd1;
          end
        end
        default: state_d = MD_IDLE;
      endcase
    end
    // A fast-path request sits in RUN for one cycle without raising busy
    busy_d = (state_d == MD_RUN) && !fast_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MD_IDLE;
      count_q   <= 6'd0;
      work_q    <= 64'd0;
      opnd_q    <= 32'd0;
      op_q      <= 3'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      fast_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      work_q    <= work_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      fast_q    <= fast_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign state  = state_q;

endmodule
